i2c_cmd_sequencer: RTL and testbench

- Transaction-level front end for the byte-level I2C bus stage.
- Accepts one request per transaction: 7-bit slave address, direction, byte count.
- Breaks each request into byte commands (START+address, data bytes, STOP) and streams write data in and read data out.
- Sits between the bus sequencer's instruction decoder (upstream) and the I2C byte/bus stage (downstream); reports one completion status per transaction.

---
 rtl/i2c_cmd_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Splits one I2C transaction request into START+address, data-byte and STOP byte commands; one status per transaction.
// Latency: the address command is issued 2 cycles after the request is accepted; done_o arrives 1 cycle after the final bus_done_i.
// Backpressure: req_ready_o only in IDLE, wr_ready_o only while waiting for a write byte; rd_valid_o is not backpressured.
// Optional macro I2C_SEQ_RSTART_EN adds req_nostop_i, which leaves the bus owned after a successful transaction.
module i2c_cmd_sequencer #(
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [6:0]       req_addr_i,
    input  logic             req_rnw_i,
    input  logic [LEN_W-1:0] req_len_i,
`ifdef I2C_SEQ_RSTART_EN
    input  logic             req_nostop_i,
`endif
    input  logic [7:0]       wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic             bus_cmd_valid_o,
    output logic             bus_start_o,
    output logic             bus_stop_o,
    output logic             bus_read_o,
    output logic             bus_write_o,
    output logic             bus_ack_o,
    output logic [7:0]       bus_din_o,
    input  logic             bus_done_i,
    input  logic             bus_rx_ack_i,
    input  logic [7:0]       bus_dout_i,
    input  logic             bus_al_i
);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NACK = 2'b01;
    localparam logic [1:0] ST_AL   = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WAIT_ADDR, S_GET_WR, S_ISSUE,
        S_WAIT_BYTE, S_STOP, S_WAIT_STOP, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         addr_q;
    logic               rnw_q;
    logic [LEN_W-1:0]   len_q;
    logic               nostop_q;
    logic [7:0]         wbyte_q;
    logic [1:0]         status_q, status_d;
    logic [TMO_W-1:0]   tmo_q;
    logic [7:0]         rd_data_q;
    logic               rd_vld_q;
    logic               start_q, stop_q, read_q, write_q, ack_q;
    logic [7:0]         din_q;
    logic               c_start, c_stop, c_read, c_write, c_ack;
    logic [7:0]         c_din;
    logic               cur_wait, nxt_wait, last, tmo_hit;

    assign cur_wait = (state_q == S_WAIT_ADDR) || (state_q == S_WAIT_BYTE) || (state_q == S_WAIT_STOP);
    assign nxt_wait = (state_d == S_WAIT_ADDR) || (state_d == S_WAIT_BYTE) || (state_d == S_WAIT_STOP);
    assign last     = (len_q == LEN_W'(1));
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && cur_wait && !bus_done_i &&
                      (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d  = S_ADDR;
                    status_d = ST_OK;
                end
            end
            S_ADDR:  state_d = S_WAIT_ADDR;
            S_WAIT_ADDR: begin
                if (bus_done_i) begin
                    if (bus_rx_ack_i) begin
                        status_d = ST_NACK;
                        state_d  = stop_q ? S_DONE : S_STOP;
                    end else if (len_q == '0) begin
                        status_d = ST_OK;
                        state_d  = S_DONE;
                    end else begin
                        state_d = rnw_q ? S_ISSUE : S_GET_WR;
                    end
                end
            end
            S_GET_WR: if (wr_valid_i) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT_BYTE;
            S_WAIT_BYTE: begin
                if (bus_done_i) begin
                    // Only writes carry a slave ACK; a NACK forces STOP unless it already went out.
                    if (!rnw_q && bus_rx_ack_i) begin
                        status_d = ST_NACK;
                        state_d  = stop_q ? S_DONE : S_STOP;
                    end else if (last) begin
                        status_d = ST_OK;
                        state_d  = S_DONE;
                    end else begin
                        state_d = rnw_q ? S_ISSUE : S_GET_WR;
                    end
                end
            end
            S_STOP:      state_d = S_WAIT_STOP;
            S_WAIT_STOP: if (bus_done_i) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_d  = S_DONE;
            status_d = ST_TMO;
        end
        // Losing arbitration outranks a completion seen in the same cycle.
        if (bus_al_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d  = S_DONE;
            status_d = ST_AL;
        end
    end

    always_comb begin
        c_start = 1'b0;
        c_stop  = 1'b0;
        c_read  = 1'b0;
        c_write = 1'b0;
        c_ack   = 1'b0;
        c_din   = 8'h00;
        case (state_q)
            S_ADDR: begin
                c_start = 1'b1;
                c_write = 1'b1;
                c_stop  = (len_q == '0) && !nostop_q;
                c_din   = {addr_q, rnw_q};
            end
            S_ISSUE: begin
                c_write = !rnw_q;
                c_read  = rnw_q;
                c_ack   = rnw_q && last;
                c_stop  = last && !nostop_q;
                c_din   = rnw_q ? 8'h00 : wbyte_q;
            end
            S_STOP:  c_stop = 1'b1;
            default: ;
        endcase
    end

`ifdef I2C_SEQ_RSTART_EN
    always_ff @(posedge clk_i) begin
        if (!nrst_i)
            nostop_q <= 1'b0;
        else if (state_q == S_IDLE && req_valid_i)
            nostop_q <= req_nostop_i;
    end
`else
    assign nostop_q = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q   <= S_IDLE;
            status_q  <= ST_OK;
            addr_q    <= '0;
            rnw_q     <= 1'b0;
            len_q     <= '0;
            wbyte_q   <= '0;
            tmo_q     <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            ack_q     <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (state_q == S_IDLE && req_valid_i) begin
                addr_q <= req_addr_i;
                rnw_q  <= req_rnw_i;
                len_q  <= req_len_i;
            end
            if (state_q == S_GET_WR && wr_valid_i)
                wbyte_q <= wr_data_i;
            if (state_q == S_WAIT_BYTE && bus_done_i && !bus_al_i && len_q != '0)
                len_q <= len_q - LEN_W'(1);
            tmo_q    <= cur_wait ? tmo_q + TMO_W'(1) : '0;
            rd_vld_q <= (state_q == S_WAIT_BYTE) && rnw_q && bus_done_i && !bus_al_i;
            if ((state_q == S_WAIT_BYTE) && rnw_q && bus_done_i && !bus_al_i)
                rd_data_q <= bus_dout_i;
            // Fields load on issue, hold while waiting, clear once the command retires.
            if (!nxt_wait) begin
                start_q <= 1'b0;
                stop_q  <= 1'b0;
                read_q  <= 1'b0;
                write_q <= 1'b0;
                ack_q   <= 1'b0;
                din_q   <= '0;
            end else if (!cur_wait) begin
                start_q <= c_start;
                stop_q  <= c_stop;
                read_q  <= c_read;
                write_q <= c_write;
                ack_q   <= c_ack;
                din_q   <= c_din;
            end
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign wr_ready_o      = (state_q == S_GET_WR);
    assign done_o          = (state_q == S_DONE);
    assign status_o        = done_o ? status_q : 2'b00;
    assign rd_data_o       = rd_data_q;
    assign rd_valid_o      = rd_vld_q;
    assign bus_cmd_valid_o = cur_wait;
    assign bus_start_o     = start_q;
    assign bus_stop_o      = stop_q;
    assign bus_read_o      = read_q;
    assign bus_write_o     = write_q;
    assign bus_ack_o       = ack_q;
    assign bus_din_o       = din_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: transaction-level model predicts commands, read bytes and status;
// a bus-stage responder drives replies and a negedge monitor compares the DUT every cycle.
module tb_i2c_cmd_sequencer;

    localparam int TMO = 16;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       rd;
        logic       wr;
        logic       ack;
        logic [7:0] din;
    } cmd_t;

    logic       clk_i = 1'b0;
    logic       nrst_i;
    logic       req_valid_i, req_ready_o, req_rnw_i;
    logic [6:0] req_addr_i;
    logic [7:0] req_len_i;
    logic [7:0] wr_data_i, rd_data_o, bus_din_o, bus_dout_i;
    logic       wr_valid_i, wr_ready_o, rd_valid_o, done_o;
    logic [1:0] status_o;
    logic       bus_cmd_valid_o, bus_start_o, bus_stop_o, bus_read_o, bus_write_o, bus_ack_o;
    logic       bus_done_i, bus_rx_ack_i, bus_al_i;

    i2c_cmd_sequencer #(.LEN_W(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .nrst_i(nrst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_rnw_i(req_rnw_i), .req_len_i(req_len_i),
`ifdef I2C_SEQ_RSTART_EN
        .req_nostop_i(1'b0),
`endif
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .done_o(done_o), .status_o(status_o),
        .bus_cmd_valid_o(bus_cmd_valid_o), .bus_start_o(bus_start_o), .bus_stop_o(bus_stop_o),
        .bus_read_o(bus_read_o), .bus_write_o(bus_write_o), .bus_ack_o(bus_ack_o),
        .bus_din_o(bus_din_o), .bus_done_i(bus_done_i), .bus_rx_ack_i(bus_rx_ack_i),
        .bus_dout_i(bus_dout_i), .bus_al_i(bus_al_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    cmd_t       exp_cmd[$];
    logic [1:0] exp_st[$];
    logic [7:0] exp_rd[$];
    int         exp_hs, exp_rdn, hs_cnt, rd_cnt;
    logic [7:0] wdata[16];
    logic [7:0] rdata[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred with nothing expected", nm);
    endtask

    function automatic cmd_t mk(input logic s, input logic p, input logic r, input logic w,
                                input logic k, input logic [7:0] d);
        cmd_t c;
        c.start = s; c.stop = p; c.rd = r; c.wr = w; c.ack = k; c.din = d;
        return c;
    endfunction

    // Transaction-level model: expected command list, read bytes, handshakes and final status.
    task automatic build_expect(input logic [6:0] a, input logic rnw, input int len,
                                input int nack_idx, input int al_at, input int tmo_at);
        exp_hs = 0;
        exp_rdn = 0;
        exp_cmd.push_back(mk(1'b1, len == 0, 1'b0, 1'b1, 1'b0, {a, rnw}));
        if (al_at == 0) begin exp_st.push_back(2'b10); return; end
        if (tmo_at == 0) begin exp_st.push_back(2'b11); return; end
        if (nack_idx == 0) begin
            if (len != 0) exp_cmd.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
            exp_st.push_back(2'b01);
            return;
        end
        if (len == 0) begin exp_st.push_back(2'b00); return; end
        for (int k = 1; k <= len; k++) begin
            logic lst;
            lst = (k == len);
            if (!rnw) exp_hs++;
            exp_cmd.push_back(mk(1'b0, lst, rnw, !rnw, rnw && lst, rnw ? 8'h00 : wdata[k-1]));
            if (al_at == k) begin exp_st.push_back(2'b10); return; end
            if (tmo_at == k) begin exp_st.push_back(2'b11); return; end
            if (rnw) begin exp_rd.push_back(rdata[k-1]); exp_rdn++; end
            if (!rnw && nack_idx == k) begin
                if (!lst) exp_cmd.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
                exp_st.push_back(2'b01);
                return;
            end
        end
        exp_st.push_back(2'b00);
    endtask

    // Per-cycle monitor.
    logic prev_vld = 1'b0, rd_due = 1'b0, al_due = 1'b0, tmo_due = 1'b0, drop_due = 1'b0;
    int   run = 0;
    cmd_t held, cur;

    always @(negedge clk_i) begin
        if (!nrst_i) begin
            prev_vld = 1'b0; rd_due = 1'b0; al_due = 1'b0; tmo_due = 1'b0; drop_due = 1'b0; run = 0;
        end else begin
            cur = mk(bus_start_o, bus_stop_o, bus_read_o, bus_write_o, bus_ack_o, bus_din_o);
            if (al_due) begin
                check("al_done", 32'(done_o), 1);
                check("al_cmd_drop", 32'(bus_cmd_valid_o), 0);
            end
            if (tmo_due) begin
                check("tmo_done", 32'(done_o), 1);
                check("tmo_cmd_drop", 32'(bus_cmd_valid_o), 0);
            end
            if (drop_due) check("cmd_drop", 32'(bus_cmd_valid_o), 0);
            if (bus_cmd_valid_o) begin
                if (!prev_vld) begin
                    if (exp_cmd.size() == 0) flag_fail("cmd_unexpected");
                    else check("cmd_fields", 32'(cur), 32'(exp_cmd.pop_front()));
                    held = cur;
                end else begin
                    check("cmd_hold", 32'(cur), 32'(held));
                end
            end
            if (done_o) begin
                if (exp_st.size() == 0) flag_fail("done_unexpected");
                else check("status", 32'(status_o), 32'(exp_st.pop_front()));
            end
            if (rd_due || rd_valid_o) begin
                check("rd_timing", 32'(rd_valid_o), 32'(rd_due));
                if (rd_valid_o) begin
                    rd_cnt++;
                    if (exp_rd.size() == 0) flag_fail("rd_unexpected");
                    else check("rd_data", 32'(rd_data_o), 32'(exp_rd.pop_front()));
                end
            end
            if (wr_valid_i && wr_ready_o) hs_cnt++;
            rd_due   = bus_cmd_valid_o && bus_read_o && bus_done_i && !bus_al_i;
            al_due   = bus_al_i && !req_ready_o && !done_o;
            drop_due = bus_cmd_valid_o && bus_done_i;
            if (bus_cmd_valid_o && !bus_done_i && !bus_al_i) run++;
            else run = 0;
            tmo_due  = (run == TMO);
            prev_vld = bus_cmd_valid_o;
        end
    end

    // Issues one request and plays the bus stage; inputs change 2 time units after posedge.
    task automatic run_txn(input logic [6:0] a, input logic rnw, input int len, input int nack_idx,
                           input int al_at, input int tmo_at, input int rst_at);
        int  cidx = 0, age = 0, widx = 0;
        bit  seen = 0, stall = 1, fin = 0;
        hs_cnt = 0;
        rd_cnt = 0;
        @(posedge clk_i); #2;
        req_valid_i = 1'b1; req_addr_i = a; req_rnw_i = rnw; req_len_i = 8'(len);
        @(posedge clk_i); #2;
        req_valid_i = 1'b0;
        check("req_ready_drop", 32'(req_ready_o), 0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            bus_done_i = 1'b0; bus_al_i = 1'b0; bus_rx_ack_i = 1'b0; bus_dout_i = 8'h00;
            if (done_o) begin fin = 1; break; end
            if (wr_ready_o) begin
                if (stall) begin wr_valid_i = 1'b0; stall = 0; end
                else begin wr_valid_i = 1'b1; wr_data_i = wdata[widx]; widx++; stall = 1; end
            end else begin
                wr_valid_i = 1'b0;
            end
            if (bus_cmd_valid_o) begin
                age  = seen ? age + 1 : 0;
                seen = 1;
                if (cidx == rst_at && age == 1) begin
                    nrst_i = 1'b0; wr_valid_i = 1'b0;
                    exp_cmd.delete(); exp_st.delete(); exp_rd.delete();
                    @(posedge clk_i); #2;
                    nrst_i = 1'b1;
                    return;
                end
                if (cidx == al_at && age == 1) bus_al_i = 1'b1;
                else if (cidx != tmo_at && age == 2) begin
                    bus_done_i   = 1'b1;
                    bus_rx_ack_i = (cidx == nack_idx) && bus_write_o;
                    bus_dout_i   = bus_read_o ? rdata[cidx-1] : 8'h00;
                    cidx++;
                end
            end else begin
                seen = 0;
            end
            @(posedge clk_i); #2;
        end
        wr_valid_i = 1'b0;
        if (!fin) check("txn_finished", 0, 1);
        @(negedge clk_i); #1;
        check("hs_count", 32'(hs_cnt), 32'(exp_hs));
        check("rd_count", 32'(rd_cnt), 32'(exp_rdn));
        check("cmd_q_empty", 32'(exp_cmd.size()), 0);
        check("st_q_empty", 32'(exp_st.size()), 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check(nm, 32'({req_ready_o, wr_ready_o, rd_valid_o, rd_data_o, done_o, status_o,
                       bus_cmd_valid_o, bus_start_o, bus_stop_o, bus_read_o, bus_write_o,
                       bus_ack_o, bus_din_o}), 32'({1'b1, 27'b0}));
    endtask

    initial begin
        nrst_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_rnw_i = 1'b0; req_len_i = '0;
        wr_data_i = '0; wr_valid_i = 1'b0; bus_done_i = 1'b0; bus_rx_ack_i = 1'b0;
        bus_dout_i = '0; bus_al_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 nrst_i = 1'b1;
        check_reset_outputs("reset_state");

        // Write 0x50, 2 bytes
        wdata[0] = 8'hA5; wdata[1] = 8'h3C;
        build_expect(7'h50, 1'b0, 2, -1, -1, -1);
        check("pin_w_addr", 32'(exp_cmd[0]), 32'(mk(1, 0, 0, 1, 0, 8'hA0)));
        check("pin_w_last", 32'(exp_cmd[2]), 32'(mk(0, 1, 0, 1, 0, 8'h3C)));
        run_txn(7'h50, 1'b0, 2, -1, -1, -1, -1);
        check("w_handshakes", 32'(hs_cnt), 2);

        // Read 0x48, 3 bytes
        rdata[0] = 8'h11; rdata[1] = 8'h22; rdata[2] = 8'h33;
        build_expect(7'h48, 1'b1, 3, -1, -1, -1);
        check("pin_r_last", 32'(exp_cmd[3]), 32'(mk(0, 1, 1, 0, 1, 8'h00)));
        run_txn(7'h48, 1'b1, 3, -1, -1, -1, -1);
        check("r_pulses", 32'(rd_cnt), 3);

        // Probe 0x7F, NACKed
        build_expect(7'h7F, 1'b0, 0, 0, -1, -1);
        check("pin_probe", 32'(exp_cmd.size()), 1);
        check("pin_probe_cmd", 32'(exp_cmd[0]), 32'(mk(1, 1, 0, 1, 0, 8'hFE)));
        run_txn(7'h7F, 1'b0, 0, 0, -1, -1, -1);

        // Write len 4, NACK on byte 2
        wdata[0] = 8'h01; wdata[1] = 8'h02; wdata[2] = 8'h03; wdata[3] = 8'h04;
        build_expect(7'h22, 1'b0, 4, 2, -1, -1);
        check("pin_nack_stop", 32'(exp_cmd[3]), 32'(mk(0, 1, 0, 0, 0, 8'h00)));
        run_txn(7'h22, 1'b0, 4, 2, -1, -1, -1);
        check("nack_handshakes", 32'(hs_cnt), 2);

        // NACK on the last byte: STOP already sent
        wdata[0] = 8'h5A; wdata[1] = 8'hC3;
        build_expect(7'h2C, 1'b0, 2, 2, -1, -1);
        run_txn(7'h2C, 1'b0, 2, 2, -1, -1, -1);

        // Arbitration lost during read byte 1
        rdata[0] = 8'h99; rdata[1] = 8'h98;
        build_expect(7'h33, 1'b1, 2, -1, 1, -1);
        check("pin_al_status", 32'(exp_st[0]), 2);
        run_txn(7'h33, 1'b1, 2, -1, 1, -1, -1);

        // Timeout on the data byte
        wdata[0] = 8'h77;
        build_expect(7'h10, 1'b0, 1, -1, -1, 1);
        run_txn(7'h10, 1'b0, 1, -1, -1, 1, -1);

        // Reset mid-transfer
        wdata[0] = 8'h61; wdata[1] = 8'h62; wdata[2] = 8'h63;
        build_expect(7'h55, 1'b0, 3, -1, -1, -1);
        run_txn(7'h55, 1'b0, 3, -1, -1, -1, 2);
        check_reset_outputs("mid_reset_state");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #2;
            check("no_done_after_reset", 32'(done_o), 0);
        end

        // Normal operation after reset
        wdata[0] = 8'hFF;
        build_expect(7'h0A, 1'b0, 1, -1, -1, -1);
        run_txn(7'h0A, 1'b0, 1, -1, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
